stopwatch: RTL and testbench

Up-counting mm:ss stopwatch: the counting-direction counterpart of the countdown timer in the controller. It starts at 00:00, advances once per second on an internal clock divider and saturates at 99:59. Start, stop, pause and lap are raw push-button levels that the block edge-detects itself. Binary minute and second values, plus a captured lap value, feed the board display path.

---
 rtl/stopwatch.sv | 160 ++++++++++++++++
 tb/tb_stopwatch.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch.sv
// stopwatch: up-counting mm:ss stopwatch, one count per CLK_DIV clocks, saturating at 99:59.
// Buttons arrive as raw levels and are edge-detected here. A lap register captures the count.
module stopwatch #(
    parameter int unsigned CLK_DIV = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       lap,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic [6:0] lap_min,
    output logic [6:0] lap_sec,
    output logic       running,
    output logic       overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause
    } state_t;

    localparam logic [31:0] TickLast = 32'(CLK_DIV - 1);

    state_t      r_state;
    logic [31:0] r_tick;
    logic [6:0]  r_min;
    logic [6:0]  r_sec;
    logic [6:0]  r_lap_min;
    logic [6:0]  r_lap_sec;
    logic        r_running;
    logic        r_overflow;

    logic        r_start_prev;
    logic        r_stop_prev;
    logic        r_pause_prev;
    logic        r_lap_prev;
    // Low until the first edge after reset release. That edge only loads the prev
    // registers, so a button held through reset is not mistaken for a press.
    logic        r_armed;

    logic        w_start_ev;
    logic        w_stop_ev;
    logic        w_pause_ev;
    logic        w_lap_ev;
    logic        w_tick_done;
    logic        w_at_max;

    assign w_start_ev  = start & ~r_start_prev & r_armed;
    assign w_stop_ev   = stop  & ~r_stop_prev  & r_armed;
    assign w_pause_ev  = pause & ~r_pause_prev & r_armed;
    assign w_lap_ev    = lap   & ~r_lap_prev   & r_armed;
    assign w_tick_done = (r_tick == TickLast);
    assign w_at_max    = (r_min == 7'd99) && (r_sec == 7'd59);

    // Register button levels every clock for rising-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_start_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
            r_pause_prev <= 1'b0;
            r_lap_prev   <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_start_prev <= start;
            r_stop_prev  <= stop;
            r_pause_prev <= pause;
            r_lap_prev   <= lap;
            r_armed      <= 1'b1;
        end
    end

    // Control FSM with the count, tick divider, lap capture and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_tick     <= 32'd0;
            r_min      <= 7'd0;
            r_sec      <= 7'd0;
            r_lap_min  <= 7'd0;
            r_lap_sec  <= 7'd0;
            r_running  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_start_ev) begin
                        r_min      <= 7'd0;
                        r_sec      <= 7'd0;
                        r_tick     <= 32'd0;
                        r_overflow <= 1'b0;
                        r_state    <= StRun;
                        r_running  <= 1'b1;
                    end
                    if (w_lap_ev) begin
                        r_lap_min <= 7'd0;
                        r_lap_sec <= 7'd0;
                    end
                end
                StRun: begin
                    if (w_stop_ev) begin
                        r_state   <= StIdle;
                        r_running <= 1'b0;
                    end else if (w_pause_ev) begin
                        r_state   <= StPause;
                        r_running <= 1'b0;
                    end else begin
                        // Lap sees the pre-edge count even when this edge also ticks.
                        if (w_lap_ev) begin
                            r_lap_min <= r_min;
                            r_lap_sec <= r_sec;
                        end
                        if (w_tick_done) begin
                            r_tick <= 32'd0;
                            if (w_at_max) begin
                                r_overflow <= 1'b1;
                                r_state    <= StIdle;
                                r_running  <= 1'b0;
                            end else if (r_sec == 7'd59) begin
                                r_sec <= 7'd0;
                                r_min <= r_min + 7'd1;
                            end else begin
                                r_sec <= r_sec + 7'd1;
                            end
                        end else begin
                            r_tick <= r_tick + 32'd1;
                        end
                    end
                end
                StPause: begin
                    // Tick counter stays frozen so the partial second survives the pause.
                    if (w_stop_ev) begin
                        r_state <= StIdle;
                    end else if (w_pause_ev || w_start_ev) begin
                        r_state   <= StRun;
                        r_running <= 1'b1;
                    end else if (w_lap_ev) begin
                        r_lap_min <= r_min;
                        r_lap_sec <= r_sec;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    assign min      = r_min;
    assign sec      = r_sec;
    assign lap_min  = r_lap_min;
    assign lap_sec  = r_lap_sec;
    assign running  = r_running;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_stopwatch.sv
// tb_stopwatch: table-driven vectors, directed corner sequences and random button
// traffic checked against a total-seconds reference model.
module tb_stopwatch;

    localparam int CLK_DIV   = 4;
    localparam int MAX_TOTAL = 99 * 60 + 59;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic       lap;
    logic [6:0] min;
    logic [6:0] sec;
    logic [6:0] lap_min;
    logic [6:0] lap_sec;
    logic       running;
    logic       overflow;

    int n_vec = 0;
    int n_err = 0;

    stopwatch #(.CLK_DIV(CLK_DIV)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .lap      (lap),
        .min      (min),
        .sec      (sec),
        .lap_min  (lap_min),
        .lap_sec  (lap_sec),
        .running  (running),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    // Reference model: count kept as total elapsed seconds, mode 0=idle 1=run 2=pause.
    int m_mode;
    int m_total;
    int m_acc;
    int m_lap;
    bit m_ovf;
    bit m_armed;
    bit m_ps, m_pt, m_pp, m_pl;

    task automatic model_reset();
        m_mode = 0; m_total = 0; m_acc = 0; m_lap = 0; m_ovf = 0; m_armed = 0;
        m_ps = 0; m_pt = 0; m_pp = 0; m_pl = 0;
    endtask

    task automatic model_step(input bit s, input bit t, input bit p, input bit l);
        bit es, et, ep, el;
        es = s && !m_ps && m_armed;
        et = t && !m_pt && m_armed;
        ep = p && !m_pp && m_armed;
        el = l && !m_pl && m_armed;
        m_ps = s; m_pt = t; m_pp = p; m_pl = l; m_armed = 1;
        if (m_mode == 0) begin
            if (es) begin
                m_total = 0; m_acc = 0; m_ovf = 0; m_mode = 1;
            end
            if (el) m_lap = 0;
        end else if (m_mode == 1) begin
            if (et) m_mode = 0;
            else if (ep) m_mode = 2;
            else begin
                if (el) m_lap = m_total;
                m_acc = m_acc + 1;
                if (m_acc == CLK_DIV) begin
                    m_acc = 0;
                    if (m_total == MAX_TOTAL) begin
                        m_ovf = 1; m_mode = 0;
                    end else begin
                        m_total = m_total + 1;
                    end
                end
            end
        end else begin
            if (et) m_mode = 0;
            else if (ep || es) m_mode = 1;
            else if (el) m_lap = m_total;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".min"},      32'(min),      32'(m_total / 60));
        check({tag, ".sec"},      32'(sec),      32'(m_total % 60));
        check({tag, ".lap_min"},  32'(lap_min),  32'(m_lap / 60));
        check({tag, ".lap_sec"},  32'(lap_sec),  32'(m_lap % 60));
        check({tag, ".running"},  32'(running),  32'(m_mode == 1));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    task automatic check_out(input string tag, input int mn, input int sc,
                             input bit run, input bit ovf);
        check({tag, ".min"},      32'(min),      32'(mn));
        check({tag, ".sec"},      32'(sec),      32'(sc));
        check({tag, ".running"},  32'(running),  32'(run));
        check({tag, ".overflow"}, 32'(overflow), 32'(ovf));
    endtask

    // Drive levels, take one rising edge, advance the model, sample 1 time unit later.
    task automatic step(input bit s, input bit t, input bit p, input bit l);
        start = s; stop = t; pause = p; lap = l;
        @(posedge clock);
        model_step(s, t, p, l);
        #1;
    endtask

    task automatic step_chk(input string tag, input bit s, input bit t, input bit p, input bit l);
        step(s, t, p, l);
        check_model(tag);
    endtask

    typedef struct {
        bit s, t, p, l;
        int sc, lsc;
        bit run;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit s, input bit t, input bit p, input bit l,
                       input int sc, input int lsc, input bit run);
        vec_t v;
        v.s = s; v.t = t; v.p = p; v.l = l; v.sc = sc; v.lsc = lsc; v.run = run;
        vq.push_back(v);
    endtask

    initial begin
        // Minutes stay 0 and overflow stays low for the whole table.
        add(0,0,0,0, 0,0,0);  // reset state
        add(1,0,0,0, 0,0,1);  // start
        add(0,0,0,0, 0,0,1);
        add(0,0,0,0, 0,0,1);
        add(0,0,0,0, 0,0,1);
        add(0,0,0,0, 1,0,1);  // first increment 4 edges after start
        add(0,0,0,0, 1,0,1);
        add(0,0,0,0, 1,0,1);
        add(0,0,0,0, 1,0,1);
        add(0,0,0,0, 2,0,1);
        add(0,0,1,0, 2,0,0);  // pause
        add(0,0,0,0, 2,0,0);
        add(0,0,0,1, 2,2,0);  // lap while paused
        add(0,0,0,0, 2,2,0);
        add(1,0,0,0, 2,2,1);  // resume with start
        add(0,0,0,0, 2,2,1);
        add(0,0,0,0, 2,2,1);
        add(0,0,0,0, 2,2,1);
        add(0,0,0,0, 3,2,1);
        add(0,0,0,1, 3,3,1);  // lap at 00:03, count continues
        add(0,0,0,0, 3,3,1);
        add(0,0,0,0, 3,3,1);
        add(0,0,0,0, 4,3,1);
        add(0,0,0,0, 4,3,1);
        add(0,0,0,0, 4,3,1);
        add(0,0,0,0, 4,3,1);
        add(0,0,1,0, 4,3,0);  // pause on tick edge: no increment
        add(0,0,0,0, 4,3,0);
        add(0,0,1,0, 4,3,1);  // resume with pause
        add(0,0,0,0, 5,3,1);  // partial second preserved
        add(0,0,0,0, 5,3,1);
        add(0,0,0,0, 5,3,1);
        add(0,0,0,0, 5,3,1);
        add(0,0,0,1, 6,5,1);  // lap on tick edge captures pre-increment
        add(0,0,0,0, 6,5,1);
        add(0,0,0,0, 6,5,1);
        add(0,0,0,0, 6,5,1);
        add(0,1,0,0, 6,5,0);  // stop on tick edge: held, no increment
        add(0,0,0,0, 6,5,0);
        add(0,0,0,1, 6,0,0);  // lap in idle clears
        add(0,0,0,0, 6,0,0);
        add(0,0,1,0, 6,0,0);  // pause ignored in idle
        add(0,0,0,0, 6,0,0);
        add(1,0,0,0, 0,0,1);  // start clears count

        reset = 1; start = 0; stop = 0; pause = 0; lap = 0;
        model_reset();
        #12;
        check_out("reset", 0, 0, 0, 0);
        check("reset.lap_min", 32'(lap_min), 32'd0);
        check("reset.lap_sec", 32'(lap_sec), 32'd0);
        reset = 0;

        foreach (vq[i]) begin
            step(vq[i].s, vq[i].t, vq[i].p, vq[i].l);
            check_out($sformatf("vec%0d", i), 0, vq[i].sc, vq[i].run, 0);
            check($sformatf("vec%0d.lap_min", i), 32'(lap_min), 32'd0);
            check($sformatf("vec%0d.lap_sec", i), 32'(lap_sec), 32'(vq[i].lsc));
        end

        // Minute rollover
        step_chk("roll_stop", 0, 1, 0, 0);
        step_chk("roll_rel", 0, 0, 0, 0);
        step_chk("roll_start", 1, 0, 0, 0);
        check_out("roll_start", 0, 0, 1, 0);
        for (int i = 1; i <= 240; i++) begin
            step_chk("roll", 0, 0, 0, 0);
            if (i == 236) check_out("roll236", 0, 59, 1, 0);
            if (i == 240) check_out("roll240", 1, 0, 1, 0);
        end

        // Saturation at 99:59
        step_chk("sat_stop", 0, 1, 0, 0);
        step_chk("sat_rel", 0, 0, 0, 0);
        step_chk("sat_start", 1, 0, 0, 0);
        for (int i = 1; i <= 24000; i++) begin
            step_chk("sat", 0, 0, 0, 0);
            if (i == 23996) check_out("sat_full", 99, 59, 1, 0);
            if (i == 24000) check_out("sat_over", 99, 59, 0, 1);
        end
        step_chk("sat_idle", 0, 0, 0, 0);
        check_out("sat_idle", 99, 59, 0, 1);
        step_chk("sat_restart", 1, 0, 0, 0);
        check_out("sat_restart", 0, 0, 1, 0);

        // Asynchronous reset mid-run, between edges
        for (int i = 0; i < 6; i++) step_chk("arst_run", 0, 0, 0, 0);
        #2 reset = 1;
        #1;
        check_out("arst", 0, 0, 0, 0);
        check("arst.lap_min", 32'(lap_min), 32'd0);
        check("arst.lap_sec", 32'(lap_sec), 32'd0);
        model_reset();
        #1 reset = 0;
        step_chk("arst_idle", 0, 0, 0, 0);
        step_chk("arst_start", 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step_chk("arst_cnt", 0, 0, 0, 0);
        check_out("arst_first_tick", 0, 1, 1, 0);

        // Button held high through reset release is not a press
        start = 1;
        #2 reset = 1;
        #2 reset = 0;
        model_reset();
        step_chk("held1", 1, 0, 0, 0);
        check_out("held1", 0, 0, 0, 0);
        step_chk("held2", 1, 0, 0, 0);
        check_out("held2", 0, 0, 0, 0);
        step_chk("held_rel", 0, 0, 0, 0);
        step_chk("held_press", 1, 0, 0, 0);
        check_out("held_press", 0, 0, 1, 0);

        // Random button traffic against the reference model
        for (int i = 0; i < 4000; i++) begin
            step_chk($sformatf("rnd%0d", i),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
                     $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
            if (i == 2000) begin
                #2 reset = 1;
                #1 model_reset();
                check_model("rnd_reset");
                #1 reset = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
